// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_unit_pkg;

  localparam int WORD_LEN = 32;
  localparam logic [WORD_LEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_LEN-1:0] instr;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pcplus4;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: hold has priority over load; otherwise a bubble is inserted.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   load,
  input  if_id_t load_data,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= load_data;
    end else begin
      q <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one-outstanding imem handshake, stall hold and branch squash.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / squash_cnt performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_LEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Stall_ID,
  input  logic                BranchTK,
  input  logic [WORD_LEN-1:0] Branch_Target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] Instruction_IF,
  output logic [WORD_LEN-1:0] PC_IF,
  output logic [WORD_LEN-1:0] PCplus4_IF,
  output logic                Valid_IF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         squash_cnt
`endif
);

  fetch_state_t        state, state_n;
  logic [WORD_LEN-1:0] pc, pc_n;
  logic [WORD_LEN-1:0] req_pc, req_pc_n;
  logic [WORD_LEN-1:0] hold_instr, hold_n;
  logic [WORD_LEN-1:0] req_pc_plus4;
  logic [WORD_LEN-1:0] redirect_pc;
  logic                accept;
  logic                branch_taken;
  logic                load;
  if_id_t              load_data;
  if_id_t              if_id_q;

  assign imem_req     = rst_n && (state == FETCH);
  assign imem_addr    = pc;
  assign accept       = imem_req && imem_ready;
  assign branch_taken = BranchTK && !Stall_ID;
  assign req_pc_plus4 = req_pc + 32'd4;
  assign redirect_pc  = Branch_Target & {{(WORD_LEN-2){1'b1}}, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_pc     <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_pc     <= req_pc_n;
      hold_instr <= hold_n;
    end
  end

  // A taken branch always wins over delivering the in-flight instruction.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_pc_n  = req_pc;
    hold_n    = hold_instr;
    load      = 1'b0;
    load_data = '{instr: hold_instr, pc: req_pc, pcplus4: req_pc_plus4, valid: 1'b1};
    case (state)
      FETCH: begin
        if (accept) begin
          req_pc_n = pc;
          state_n  = WAIT;
        end
        if (branch_taken) begin
          pc_n = redirect_pc;
          if (accept) state_n = DISCARD;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          pc_n    = redirect_pc;
          state_n = imem_rvalid ? FETCH : DISCARD;
        end else if (imem_rvalid) begin
          if (Stall_ID) begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            load            = 1'b1;
            load_data.instr = imem_rdata;
            pc_n            = req_pc_plus4;
            state_n         = FETCH;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (!Stall_ID) begin
          load    = 1'b1;
          pc_n    = req_pc_plus4;
          state_n = FETCH;
        end
      end
      DISCARD: begin
        if (branch_taken) pc_n = redirect_pc;
        if (imem_rvalid) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (Stall_ID),
    .load     (load),
    .load_data(load_data),
    .q        (if_id_q)
  );

  assign Instruction_IF = if_id_q.instr;
  assign PC_IF          = if_id_q.pc;
  assign PCplus4_IF     = if_id_q.pcplus4;
  assign Valid_IF       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (load && !Stall_ID) fetch_cnt <= fetch_cnt + 32'd1;
      if (branch_taken) squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the model tracks the architectural next-PC
// stream (sequential, redirected by honoured branches/reset) and a memory with random latency.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall_ID = 1'b0;
  logic        BranchTK = 1'b0;
  logic [31:0] Branch_Target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_IF;
  logic [31:0] PCplus4_IF;
  logic        Valid_IF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Stall_ID      (Stall_ID),
    .BranchTK      (BranchTK),
    .Branch_Target (Branch_Target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .Instruction_IF(Instruction_IF),
    .PC_IF         (PC_IF),
    .PCplus4_IF    (PCplus4_IF),
    .Valid_IF      (Valid_IF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .squash_cnt    (squash_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // What the driver applied for the upcoming clock edge, read by the monitor afterwards.
  logic        e_rst = 1'b1;
  logic        e_stall = 1'b0;
  logic        e_branch = 1'b0;
  logic        e_req = 1'b0;
  logic        e_acc = 1'b0;
  logic        e_overlap = 1'b0;
  logic        e_zw = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_target = '0;
  int          edge_idx = 0;

  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        zw_mode = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        redirect_pend = 1'b0;
  logic [31:0] redirect_addr = '0;
  int          last_del = -1;
  logic [31:0] p_instr = '0;
  logic [31:0] p_pc = '0;
  logic        p_valid = 1'b0;
  int          del_cnt = 0;
  int          sq_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic [31:0] tgt, input logic rdy);
    logic resp_now;
    @(negedge clk);
    rst_n         = !rst;
    Stall_ID      = stall;
    BranchTK      = br;
    Branch_Target = tgt;
    imem_ready    = rdy;
    resp_now      = mem_busy && (edge_idx >= mem_due);
    imem_rvalid   = resp_now;
    imem_rdata    = resp_now ? mem_word(mem_addr) : $urandom;
    #1;
    e_rst     = rst;
    e_stall   = stall && !rst;
    e_branch  = !rst && br && !stall;
    e_req     = imem_req;
    e_acc     = imem_req && imem_ready;
    e_addr    = imem_addr;
    e_target  = tgt & 32'hFFFF_FFFC;
    e_overlap = e_acc && mem_busy && !resp_now;
    e_zw      = zw_mode;
    if (resp_now) mem_busy = 1'b0;
    if (e_acc) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_due  = edge_idx + int'($urandom_range(lat_max, lat_min));
    end
    edge_idx++;
  endtask

  // Monitor: interprets each edge against the architectural model and the scoreboard queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!e_zw) last_del = -1;
      if (e_acc) begin
        checkOutput("one_outstanding", 32'(e_overlap), 32'd0);
        if (redirect_pend) begin
          checkOutput("redirect_addr", e_addr, redirect_addr);
          redirect_pend = 1'b0;
        end
      end
      if (!e_rst && e_req && !e_acc) begin
        checkOutput("req_held", 32'(imem_req), 32'd1);
        checkOutput("req_addr", imem_addr, e_branch ? e_target : e_addr);
      end
      if (e_rst) begin
        checkOutput("rst_valid", 32'(Valid_IF), 32'd0);
        checkOutput("rst_instr", Instruction_IF, NOP);
        checkOutput("rst_pc", PC_IF, 32'd0);
        checkOutput("rst_pc4", PCplus4_IF, 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        redirect_pend = 1'b1;
        redirect_addr = RESET_PC;
        last_del = -1;
        del_cnt = 0;
        sq_cnt = 0;
      end else if (e_stall) begin
        checkOutput("stall_instr", Instruction_IF, p_instr);
        checkOutput("stall_pc", PC_IF, p_pc);
        checkOutput("stall_valid", 32'(Valid_IF), 32'(p_valid));
      end else if (e_branch) begin
        checkOutput("squash_valid", 32'(Valid_IF), 32'd0);
        checkOutput("squash_instr", Instruction_IF, NOP);
        checkOutput("squash_pc", PC_IF, 32'd0);
        exp_q.delete();
        exp_q.push_back(e_target);
        redirect_pend = 1'b1;
        redirect_addr = e_target;
        last_del = -1;
        sq_cnt++;
      end else if (Valid_IF) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_pc = exp_q.pop_front();
          checkOutput("deliv_pc", PC_IF, exp_pc);
          checkOutput("deliv_instr", Instruction_IF, mem_word(exp_pc));
          checkOutput("deliv_pc4", PCplus4_IF, exp_pc + 32'd4);
          exp_q.push_back(exp_pc + 32'd4);
        end
        del_cnt++;
        if (e_zw && last_del >= 0) checkOutput("zero_wait_interval", 32'(edge_idx - last_del), 32'd2);
        last_del = e_zw ? edge_idx : -1;
      end else begin
        checkOutput("bubble_instr", Instruction_IF, NOP);
        checkOutput("bubble_pc", PC_IF, 32'd0);
        checkOutput("bubble_pc4", PCplus4_IF, 32'd0);
      end
      p_instr = Instruction_IF;
      p_pc    = PC_IF;
      p_valid = Valid_IF;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        stall, br, rdy, found;
    logic [31:0] tgt;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    zw_mode = 1'b1;
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    zw_mode = 1'b0;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    lat_min = 2;
    lat_max = 2;
    repeat (4) begin
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    end

    lat_min = 1;
    lat_max = 3;
    repeat (2000) begin
      stall = ($urandom_range(3, 0) == 0);
      br    = ($urandom_range(19, 0) == 0);
      tgt   = $urandom;
      rdy   = ($urandom_range(9, 0) < 7);
      applyStimulus(1'b0, stall, br, tgt, rdy);
    end

    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (e_acc) found = 1'b1;
    end
    if (!found) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected one within 20 cycles");
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    mem_busy = 1'b0;
    lat_min = 1;
    lat_max = 1;
    zw_mode = 1'b1;
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    @(posedge clk);
    #2;
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetch_cnt", fetch_cnt, 32'(del_cnt));
    checkOutput("squash_cnt", squash_cnt, 32'(sq_cnt));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
